gpu_mat_vec_mul: RTL and testbench

GPU_MAT_VEC_MUL -- requirements
Module: gpu_mat_vec_mul

---
 rtl/gpu_mat_vec_mul.sv | 105 ++++++++++
 tb/tb_gpu_mat_vec_mul.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_mat_vec_mul.sv
// 4x4 matrix-vector multiply in 4.12 fixed point, one matrix row per cycle.
// Rows are fetched from an external register file; results are saturated per lane.
module gpu_mat_vec_mul #(
  parameter int MAT_COUNT = 4,
  localparam int IW = (MAT_COUNT > 1) ? $clog2(MAT_COUNT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_mat_idx,
  input  logic [63:0]   in_vec,
  output logic [IW-1:0] row_mat_idx,
  output logic [1:0]    row_idx,
  input  logic [63:0]   row_vals,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_vec,
  output logic          out_sat,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ROW, DONE} state_t;

  localparam logic signed [21:0] LANE_MAX = 22'sd32767;
  localparam logic signed [21:0] LANE_MIN = -22'sd32768;

  state_t state, state_next;

  logic [63:0]        vec_q;
  logic [63:0]        result_q;
  logic               sat_q;
  logic signed [31:0] prod [4];
  logic signed [33:0] dot_sum;
  logic signed [21:0] shifted;
  logic [15:0]        lane_res;
  logic               lane_sat;

  wire accept = in_valid && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = ROW;
      ROW:  if (row_idx == 2'd3) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Sum is kept wide enough that four full-scale products cannot wrap before the
  // arithmetic shift, so saturation sees the true magnitude.
  always_comb begin
    dot_sum = '0;
    for (int k = 0; k < 4; k++) begin
      prod[k] = $signed(row_vals[16*k +: 16]) * $signed(vec_q[16*k +: 16]);
      dot_sum = dot_sum + {{2{prod[k][31]}}, prod[k]};
    end
    shifted  = 22'(dot_sum >>> 12);
    lane_sat = 1'b0;
    lane_res = shifted[15:0];
    if (shifted > LANE_MAX) begin
      lane_res = 16'h7FFF;
      lane_sat = 1'b1;
    end else if (shifted < LANE_MIN) begin
      lane_res = 16'h8000;
      lane_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q       <= '0;
      row_mat_idx <= '0;
      row_idx     <= '0;
      result_q    <= '0;
      sat_q       <= 1'b0;
    end else if (accept) begin
      vec_q       <= in_vec;
      row_mat_idx <= in_mat_idx;
      row_idx     <= '0;
      result_q    <= '0;
      sat_q       <= 1'b0;
    end else if (state == ROW) begin
      result_q[16*row_idx +: 16] <= lane_res;
      sat_q   <= sat_q | lane_sat;
      row_idx <= row_idx + 2'd1;
    end
  end

  assign out_vec = result_q;
  assign out_sat = sat_q;

endmodule

// File: tb/tb_gpu_mat_vec_mul.sv
// Directed bench for gpu_mat_vec_mul: table of hand-computed products plus
// backpressure, mid-operation reset and back-to-back throughput sequences.
module tb_gpu_mat_vec_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mat_idx;
  logic [63:0] in_vec;
  logic [1:0]  row_mat_idx;
  logic [1:0]  row_idx;
  logic [63:0] row_vals;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_vec;
  logic        out_sat;
  logic        busy;

  logic [63:0] mat_mem [4][4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  mat;
    logic [63:0] vec;
    logic [63:0] exp_vec;
    logic        exp_sat;
  } vector_t;

  vector_t tbl [6];

  always #5 clk = ~clk;

  assign row_vals = mat_mem[row_mat_idx][row_idx];

  gpu_mat_vec_mul #(.MAT_COUNT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mat_idx(in_mat_idx), .in_vec(in_vec),
    .row_mat_idx(row_mat_idx), .row_idx(row_idx), .row_vals(row_vals),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_sat(out_sat), .busy(busy)
  );

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, waits for the result and completes the transfer.
  task automatic apply_stimulus(input logic [1:0] mat, input logic [63:0] vec,
                                output logic [63:0] got_vec, output logic got_sat,
                                output int latency);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      next_cycle();
      waited++;
    end
    if (!in_ready) check_output("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid   = 1'b1;
    in_mat_idx = mat;
    in_vec     = vec;
    next_cycle();
    in_valid = 1'b0;
    latency  = 1;
    while (!out_valid && latency < 20) begin
      next_cycle();
      latency++;
    end
    got_vec   = out_vec;
    got_sat   = out_sat;
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] got_vec;
    logic        got_sat;
    logic [63:0] held_vec;
    int          latency;
    int          waited;
    int          b2b [3];
    int          acc_cnt;
    int          res_cnt;
    int          last_acc;

    mat_mem[0][0] = 64'h0000_0000_0000_1000;
    mat_mem[0][1] = 64'h0000_0000_1000_0000;
    mat_mem[0][2] = 64'h0000_1000_0000_0000;
    mat_mem[0][3] = 64'h1000_0000_0000_0000;
    for (int r = 0; r < 4; r++) mat_mem[1][r] = 64'h7FFF_7FFF_7FFF_7FFF;
    mat_mem[2][0] = 64'h0000_0000_0000_F000;
    mat_mem[2][1] = 64'h0000_0000_0000_FFFF;
    mat_mem[2][2] = 64'h0000_0000_0000_0001;
    mat_mem[2][3] = 64'h0000_0000_0000_0003;
    mat_mem[3][0] = 64'h1000_1000_1000_1000;
    mat_mem[3][1] = 64'h0000_0000_0000_2000;
    mat_mem[3][2] = 64'hF000_0000_0000_0000;
    mat_mem[3][3] = 64'h0000_0000_0800_0800;

    tbl[0] = '{2'd0, 64'h0001_F000_0800_1000, 64'h0001_F000_0800_1000, 1'b0};
    tbl[1] = '{2'd1, 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 1'b1};
    tbl[2] = '{2'd1, 64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b1};
    tbl[3] = '{2'd2, 64'h0000_0000_0000_0800, 64'h0001_0000_FFFF_F800, 1'b0};
    tbl[4] = '{2'd3, 64'h0080_0100_0200_0400, 64'h0300_FF80_0800_0780, 1'b0};
    tbl[5] = '{2'd3, 64'h1234_0000_7000_7000, 64'h7000_EDCC_7FFF_7FFF, 1'b1};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_mat_idx = '0;
    in_vec     = '0;
    out_ready  = 1'b0;
    next_cycle();
    next_cycle();
    check_output("reset_out_valid", 64'(out_valid), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_out_vec", out_vec, 64'd0);
    check_output("reset_out_sat", 64'(out_sat), 64'd0);
    check_output("reset_row_idx", 64'(row_idx), 64'd0);
    check_output("reset_row_mat_idx", 64'(row_mat_idx), 64'd0);
    rst = 1'b0;
    next_cycle();
    check_output("in_ready_after_reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tbl[i].mat, tbl[i].vec, got_vec, got_sat, latency);
      check_output($sformatf("vec%0d_out_vec", i), got_vec, tbl[i].exp_vec);
      check_output($sformatf("vec%0d_out_sat", i), 64'(got_sat), 64'(tbl[i].exp_sat));
      check_output($sformatf("vec%0d_latency", i), 64'(latency), 64'd5);
      check_output($sformatf("vec%0d_in_ready_after", i), 64'(in_ready), 64'd1);
    end

    // Backpressure: result must hold while out_ready is low and new requests are ignored.
    in_valid   = 1'b1;
    in_mat_idx = tbl[5].mat;
    in_vec     = tbl[5].vec;
    next_cycle();
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 20) begin
      next_cycle();
      waited++;
    end
    check_output("hold_reached_done", 64'(out_valid), 64'd1);
    held_vec = out_vec;
    check_output("hold_initial_vec", held_vec, tbl[5].exp_vec);
    for (int c = 0; c < 10; c++) begin
      in_valid   = c[0];
      in_mat_idx = 2'd0;
      in_vec     = 64'h1111_2222_3333_4444;
      next_cycle();
      check_output($sformatf("hold%0d_out_vec", c), out_vec, tbl[5].exp_vec);
      check_output($sformatf("hold%0d_out_valid", c), 64'(out_valid), 64'd1);
      check_output($sformatf("hold%0d_in_ready", c), 64'(in_ready), 64'd0);
      check_output($sformatf("hold%0d_out_sat", c), 64'(out_sat), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    check_output("hold_release_out_valid", 64'(out_valid), 64'd0);
    check_output("hold_release_in_ready", 64'(in_ready), 64'd1);
    next_cycle();
    check_output("hold_single_transfer", 64'(busy), 64'd0);

    // Reset in the middle of a request, then a fresh request must complete normally.
    in_valid   = 1'b1;
    in_mat_idx = tbl[1].mat;
    in_vec     = tbl[1].vec;
    next_cycle();
    in_valid = 1'b0;
    waited = 0;
    while (row_idx != 2'd2 && waited < 10) begin
      next_cycle();
      waited++;
    end
    check_output("midrst_reached_row2", 64'(row_idx), 64'd2);
    check_output("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    next_cycle();
    check_output("midrst_out_valid", 64'(out_valid), 64'd0);
    check_output("midrst_busy", 64'(busy), 64'd0);
    check_output("midrst_in_ready", 64'(in_ready), 64'd1);
    check_output("midrst_out_vec", out_vec, 64'd0);
    check_output("midrst_out_sat", 64'(out_sat), 64'd0);
    apply_stimulus(tbl[4].mat, tbl[4].vec, got_vec, got_sat, latency);
    check_output("midrst_new_vec", got_vec, tbl[4].exp_vec);
    check_output("midrst_new_sat", 64'(got_sat), 64'd0);

    // Back-to-back with out_ready tied high: accepts every 6 cycles, results in order.
    b2b       = '{0, 4, 3};
    acc_cnt   = 0;
    res_cnt   = 0;
    last_acc  = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && res_cnt < 3; c++) begin
      if (acc_cnt < 3) begin
        in_valid   = 1'b1;
        in_mat_idx = tbl[b2b[acc_cnt]].mat;
        in_vec     = tbl[b2b[acc_cnt]].vec;
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (acc_cnt > 0) check_output($sformatf("b2b_spacing%0d", acc_cnt), 64'(c - last_acc), 64'd6);
        last_acc = c;
        acc_cnt++;
      end
      if (out_valid) begin
        check_output($sformatf("b2b_result%0d", res_cnt), out_vec, tbl[b2b[res_cnt]].exp_vec);
        res_cnt++;
      end
      next_cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output("b2b_result_count", 64'(res_cnt), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
